// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS registers on the data bus,
// a small byte FIFO, and a serializer FSM that streams frames back to back.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        uart_tx,
  output logic        tx_idle
);

  localparam int             AW         = $clog2(FIFO_DEPTH);
  localparam int             CW         = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  LAST_TICK  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // Bus decode
  logic       w_hit;
  logic [1:0] w_off;
  logic       w_wr_txdata;
  logic       w_wr_status;
  logic       w_rd_status;
  logic       w_unused;

  assign w_hit       = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_off       = addr[3:2];
  assign w_wr_txdata = mem_write && w_hit && (w_off == OFF_TXDATA);
  assign w_wr_status = mem_write && w_hit && (w_off == OFF_STATUS);
  assign w_rd_status = mem_read  && w_hit && (w_off == OFF_STATUS);
  assign w_unused    = ^{addr[1:0], write_data[31:8]};

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_next;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          r_overflow;

  assign w_full  = (r_count == FULL_COUNT);
  assign w_empty = (r_count == '0);
  // A full FIFO still accepts a push when the serializer pops on the same edge.
  assign w_push  = w_wr_txdata && (!w_full || w_pop);
  assign w_drop  = w_wr_txdata && w_full && !w_pop;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + (AW + 1)'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= write_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= w_count_next;
    end
  end

  // A dropped push outranks a same-cycle clear request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (w_wr_status && write_data[3]) begin
      r_overflow <= 1'b0;
    end
  end

  // Serializer
  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_tick;
  logic [CW-1:0] w_tick_next;
  logic [CW-1:0] w_tick_inc;
  logic          w_tick_done;
  logic [2:0]    r_bit_idx;
  logic [2:0]    w_bit_idx_next;
  logic [2:0]    w_bit_idx_inc;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_next;
  logic          r_tx;
  logic          w_tx_next;
  logic          r_tx_idle;

  assign w_tick_inc    = r_tick + CW'(1);
  assign w_tick_done   = (r_tick == LAST_TICK);
  assign w_bit_idx_inc = r_bit_idx + 3'd1;

  always_comb begin
    w_state_next   = r_state;
    w_tick_next    = r_tick;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_tx_next      = r_tx;
    w_pop          = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_tx_next   = 1'b1;
        w_tick_next = '0;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_rptr];
          w_state_next = S_START;
          w_tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (w_tick_done) begin
          w_tick_next    = '0;
          w_bit_idx_next = 3'd0;
          w_state_next   = S_DATA;
          w_tx_next      = r_shift[0];
        end else begin
          w_tick_next = w_tick_inc;
        end
      end
      S_DATA: begin
        if (w_tick_done) begin
          w_tick_next = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_bit_idx_next = w_bit_idx_inc;
            w_tx_next      = r_shift[w_bit_idx_inc];
          end
        end else begin
          w_tick_next = w_tick_inc;
        end
      end
      S_STOP: begin
        if (w_tick_done) begin
          w_tick_next = '0;
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_shift_next = r_mem[r_rptr];
            w_state_next = S_START;
            w_tx_next    = 1'b0;
          end else begin
            w_state_next = S_IDLE;
            w_tx_next    = 1'b1;
          end
        end else begin
          w_tick_next = w_tick_inc;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tick_next  = '0;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tick    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_tx_idle <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_tick    <= w_tick_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
      r_tx_idle <= (w_state_next == S_IDLE) && (w_count_next == '0);
    end
  end

  // STATUS read path
  logic [31:0] w_count_wide;
  logic [3:0]  w_count_sat;
  logic        w_busy;
  logic [31:0] w_status;

  assign w_count_wide = 32'(r_count);
  assign w_count_sat  = (w_count_wide > 32'd15) ? 4'hF : w_count_wide[3:0];
  assign w_busy       = (r_state != S_IDLE);
  assign w_status     = {24'b0, w_count_sat, r_overflow, w_busy, w_empty, w_full};

  assign read_data = w_rd_status ? w_status : 32'b0;
  assign uart_tx   = r_tx;
  assign tx_idle   = r_tx_idle;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: a timing model predicts frame start edges,
// FIFO occupancy and status; a monitor decodes the serial line independently.
module tb_mmio_uart_tx;

  localparam int          C     = 4;
  localparam int          DEPTH = 8;
  localparam int          FRAME = 10 * C;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        uart_tx;
  logic        tx_idle;

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .write_data(write_data),
    .read_data (read_data),
    .uart_tx   (uart_tx),
    .tx_idle   (tx_idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [7:0] data;
    int         startEdge;
  } frame_t;

  frame_t expQ[$];
  int     wrT[$];
  int     popT[$];
  int     freeAt;
  bit     ovf;
  bit     started = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: each accepted byte is popped one edge after its write, or as soon as
  // the previous frame ends; it then occupies the line for FRAME cycles.
  function automatic int occAfter(input int e);
    int n = 0;
    foreach (wrT[i]) if (wrT[i] <= e && popT[i] > e) n++;
    return n;
  endfunction

  function automatic bit busyAfter(input int e);
    foreach (popT[i]) if (popT[i] <= e && e < popT[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] modelStatus(input int e);
    int         c;
    logic [3:0] sat;
    c   = occAfter(e);
    sat = (c > 15) ? 4'hF : 4'(c);
    return {24'b0, sat, ovf, busyAfter(e), (c == 0), (c == DEPTH)};
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a, input int e);
    if (a[31:4] != BASE[31:4]) return 32'b0;
    if (a[3:2] == 2'd1) return modelStatus(e);
    return 32'b0;
  endfunction

  task automatic modelWrite(input logic [31:0] a, input logic [31:0] wd, input int k);
    int occ;
    int popsNow;
    int p;
    frame_t f;
    if (a[31:4] != BASE[31:4]) return;
    if (a[3:2] == 2'd0) begin
      occ     = occAfter(k - 1);
      popsNow = 0;
      foreach (popT[i]) if (popT[i] == k) popsNow++;
      if (occ - popsNow < DEPTH) begin
        p      = (k + 1 > freeAt) ? k + 1 : freeAt;
        freeAt = p + FRAME;
        wrT.push_back(k);
        popT.push_back(p);
        f.data      = wd[7:0];
        f.startEdge = p;
        expQ.push_back(f);
      end else begin
        ovf = 1'b1;
      end
    end else if (a[3:2] == 2'd1) begin
      if (wd[3]) ovf = 1'b0;
    end
  endtask

  task automatic clearModel();
    wrT.delete();
    popT.delete();
    expQ.delete();
    freeAt = 0;
    ovf    = 1'b0;
  endtask

  // Called at a falling edge; the access is sampled at the next rising edge.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] a,
                               input logic [31:0] wd, output logic [31:0] rdata);
    logic [31:0] expRd;
    mem_read   = rd;
    mem_write  = wr;
    addr       = a;
    write_data = wd;
    expRd = rd ? modelRead(a, cyc) : 32'b0;
    #1;
    rdata = read_data;
    checkOutput("read_data", rdata, expRd);
    if (wr) modelWrite(a, wd, cyc + 1);
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 32'(expQ.size()), 32'd0);
    idleCycles(2);
  endtask

  task automatic checkIdleNow();
    checkOutput("tx_idle", {31'b0, tx_idle},
                {31'b0, (!busyAfter(cyc) && occAfter(cyc) == 0)});
  endtask

  // Line monitor: decodes frames from the serial output and scores them.
  initial begin : monitor
    logic       prevTx;
    logic [9:0] bits;
    int         s;
    bit         aborted;
    frame_t     f;
    prevTx = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (reset) started = 1'b1;
      if (!started) continue;
      checkIdleNow();
      if (!reset && uart_tx === 1'b0 && prevTx === 1'b1) begin
        s       = cyc;
        bits    = '0;
        aborted = 1'b0;
        for (int j = 1; j < FRAME; j++) begin
          @(posedge clk);
          #1;
          checkIdleNow();
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          if (j % C == 0) bits[j / C] = uart_tx;
          else checkOutput("bit_stable", {31'b0, uart_tx}, {31'b0, bits[j / C]});
        end
        if (!aborted) begin
          checkOutput("stop_bit", {31'b0, bits[9]}, 32'd1);
          if (expQ.size() == 0) begin
            checkOutput("unexpected_frame", 32'(s), 32'hFFFF_FFFF);
          end else begin
            f = expQ.pop_front();
            checkOutput("frame_data", {24'b0, bits[8:1]}, {24'b0, f.data});
            checkOutput("frame_start", 32'(s), 32'(f.startEdge));
          end
        end
      end
      prevTx = uart_tx;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] rd;
    logic [31:0] a;
    int          k;
    int          p;
    int          n;
    reset      = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr       = 32'b0;
    write_data = 32'b0;
    clearModel();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset_uart_tx", {31'b0, uart_tx}, 32'd1);
    checkOutput("reset_tx_idle", {31'b0, tx_idle}, 32'd1);
    applyStimulus(1'b1, 1'b0, BASE + 32'd4, 32'd0, rd);
    checkOutput("reset_status", rd, 32'h0000_0002);

    $display("[TB] single frame 0xA5");
    applyStimulus(1'b0, 1'b1, BASE, 32'h0000_00A5, rd);
    idleCycles(FRAME + 4);
    checkOutput("single_idle", {31'b0, tx_idle}, 32'd1);

    $display("[TB] overflow");
    applyStimulus(1'b0, 1'b1, BASE, 32'h0000_0011, rd);
    for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 1'b1, BASE, 32'h20 + 32'(i), rd);
    applyStimulus(1'b1, 1'b0, BASE + 32'd4, 32'd0, rd);
    checkOutput("fill_status", rd, 32'h0000_0085);
    applyStimulus(1'b0, 1'b1, BASE, 32'h0000_0099, rd);
    applyStimulus(1'b1, 1'b0, BASE + 32'd4, 32'd0, rd);
    checkOutput("overflow_set", rd, 32'h0000_008D);
    applyStimulus(1'b0, 1'b1, BASE + 32'd4, 32'h0000_0008, rd);
    applyStimulus(1'b1, 1'b0, BASE + 32'd4, 32'd0, rd);
    checkOutput("overflow_clear", rd, 32'h0000_0085);
    waitDrain(12 * FRAME);

    $display("[TB] back-to-back frames");
    applyStimulus(1'b0, 1'b1, BASE, 32'h0000_0000, rd);
    applyStimulus(1'b0, 1'b1, BASE, 32'h0000_00FF, rd);
    waitDrain(3 * FRAME);

    $display("[TB] address miss");
    applyStimulus(1'b0, 1'b1, BASE + 32'd16, 32'h0000_0055, rd);
    applyStimulus(1'b1, 1'b0, BASE + 32'd12, 32'd0, rd);
    checkOutput("miss_reserved_read", rd, 32'd0);
    applyStimulus(1'b1, 1'b0, BASE + 32'd20, 32'd0, rd);
    checkOutput("miss_outside_read", rd, 32'd0);
    applyStimulus(1'b1, 1'b0, BASE + 32'd4, 32'd0, rd);
    checkOutput("miss_status", rd, 32'h0000_0002);
    idleCycles(FRAME);

    $display("[TB] reset mid-frame");
    k = cyc + 1;
    p = k + 1;
    applyStimulus(1'b0, 1'b1, BASE, 32'h0000_003C, rd);
    n = 0;
    while (cyc < p + 4 * C && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    clearModel();
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midreset_uart_tx", {31'b0, uart_tx}, 32'd1);
    applyStimulus(1'b1, 1'b0, BASE + 32'd4, 32'd0, rd);
    checkOutput("midreset_status", rd, 32'h0000_0002);
    idleCycles(3 * FRAME);
    checkOutput("midreset_idle", {31'b0, tx_idle}, 32'd1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: applyStimulus(1'b0, 1'b1, BASE, $urandom, rd);
        4:          applyStimulus(1'b1, 1'b0, BASE + 32'd4, 32'd0, rd);
        5:          applyStimulus(1'b0, 1'b1, BASE + 32'd4, $urandom, rd);
        6:          applyStimulus(1'b1, 1'b1, BASE + 32'd4, $urandom, rd);
        7:          idleCycles($urandom_range(1, 40));
        8: begin
          a = $urandom & 32'hFFFF_FFFC;
          if (a[31:4] == BASE[31:4]) a[4] = ~a[4];
          applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, rd);
        end
        default: begin
          a = BASE + 32'(4 * $urandom_range(0, 3));
          applyStimulus(1'b1, 1'($urandom_range(0, 1)), a, $urandom, rd);
        end
      endcase
    end
    waitDrain(200 * FRAME);
    checkOutput("final_idle", {31'b0, tx_idle}, 32'd1);
    applyStimulus(1'b1, 1'b0, BASE + 32'd4, 32'd0, rd);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
